pc_gen: RTL and testbench

- Registered program-counter generator; the sequential, parametrised successor to the combinational next-PC logic.
- Holds the fetch PC and offers it to instruction fetch over a valid/ready handshake.
- Resolves execute-stage redirects (branch/JAL/JALR) and trap redirects.
- Detects misaligned targets and halts fetch until a trap redirect or reset.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_target.sv | 42 ++++
 rtl/pc_gen.sv | 150 +++++++++++++++
 tb/tb_pc_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_gen_pkg : shared types and constants for the PC generator         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int unsigned INSTR_STEP_32 = 4;
    localparam int unsigned INSTR_STEP_16 = 2;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_target : execute-stage redirect target select and alignment check |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module pc_target #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm_data,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            ex_valid,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch_taken,
    output logic [XLEN-1:0] target,
    output logic            ex_redir,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] c_lsb_clear = ~{{(XLEN-1){1'b0}}, 1'b1};

    // JALR outranks JAL and taken branches; the latter two share one adder.
    always_comb begin
        if (is_jalr) begin
            target = (rs1_data + imm_data) & c_lsb_clear;
        end else begin
            target = ex_pc + imm_data;
        end
        ex_redir = ex_valid && (is_jalr || is_jal || (is_branch && branch_taken));
    end

    if (IALIGN == 16) begin : g_align16
        assign misaligned = 1'b0;
    end else begin : g_align32
        assign misaligned = target[1];
    end

endmodule : pc_target
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_gen   : registered fetch PC with redirect, trap and halt handling  |
// |            Optional redirect counter: define PC_GEN_PERF_CNT_EN.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              IALIGN       = 32,
    parameter int              CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm_data,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch_taken,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            redirect,
    output logic            misalign_err,
`ifdef PC_GEN_PERF_CNT_EN
    output logic [CNT_W-1:0] redirect_count,
`endif
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] c_step = (IALIGN == 16) ? XLEN'(INSTR_STEP_16)
                                                        : XLEN'(INSTR_STEP_32);

    if ((CNT_W < 1) || ((IALIGN != 32) && (IALIGN != 16))) begin : g_param_check
        $error("pc_gen: illegal CNT_W or IALIGN");
    end

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            misalign_err_q, misalign_err_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

    logic [XLEN-1:0] w_target;
    logic            w_ex_redir;
    logic            w_misaligned;

    pc_target #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_pc_target (
        .ex_pc        (ex_pc),
        .imm_data     (imm_data),
        .rs1_data     (rs1_data),
        .ex_valid     (ex_valid),
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .branch_taken (branch_taken),
        .target       (w_target),
        .ex_redir     (w_ex_redir),
        .misaligned   (w_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            pc_q            <= RESET_VECTOR;
            redirect_q      <= 1'b0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_q      <= redirect_d;
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    // A trap wins from any state; execute redirects only count while running.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_d      = 1'b0;
        misalign_err_d  = 1'b0;
        misalign_addr_d = misalign_addr_q;
        if (trap_valid) begin
            state_d    = RUN;
            pc_d       = trap_vector;
            redirect_d = 1'b1;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (w_ex_redir && !w_misaligned) begin
                        pc_d       = w_target;
                        redirect_d = 1'b1;
                    end else if (w_ex_redir) begin
                        state_d         = HALT;
                        misalign_err_d  = 1'b1;
                        misalign_addr_d = w_target;
                    end else if (fetch_ready) begin
                        pc_d = pc_q + c_step;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_comb begin
        fetch_valid   = (state_q == RUN);
        pc            = pc_q;
        redirect      = redirect_q;
        misalign_err  = misalign_err_q;
        misalign_addr = misalign_addr_q;
    end

`ifdef PC_GEN_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (redirect_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_count = cnt_q;
`endif

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_gen : directed and random checking of pc_gen against a model   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_pc_gen;

    localparam logic [31:0] c_rv = 32'h0000_1000;
`ifdef PC_GEN_PERF_CNT_EN
    localparam int c_cnt_w = 2;
`else
    localparam int c_cnt_w = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, is_branch, is_jal, is_jalr, branch_taken;
    logic [31:0] ex_pc, imm_data, rs1_data;
    logic        trap_valid, fetch_ready;
    logic [31:0] trap_vector;
    logic        fetch_valid, redirect, misalign_err;
    logic [31:0] pc, misalign_addr;
`ifdef PC_GEN_PERF_CNT_EN
    logic [c_cnt_w-1:0] redirect_count;
`endif

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (c_rv),
        .IALIGN       (32),
        .CNT_W        (c_cnt_w)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .imm_data     (imm_data),
        .rs1_data     (rs1_data),
        .is_branch    (is_branch),
        .is_jal       (is_jal),
        .is_jalr      (is_jalr),
        .branch_taken (branch_taken),
        .trap_valid   (trap_valid),
        .trap_vector  (trap_vector),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .redirect     (redirect),
        .misalign_err (misalign_err),
`ifdef PC_GEN_PERF_CNT_EN
        .redirect_count (redirect_count),
`endif
        .misalign_addr (misalign_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_maddr;
    logic        m_redirect, m_merr;
    int          m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = c_rv; m_maddr = 0;
        m_redirect = 0; m_merr = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        bit          wants;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_redirect && m_cnt < (1 << c_cnt_w) - 1) m_cnt++;
        wants = ex_valid && (is_jalr || is_jal || (is_branch && branch_taken));
        tgt   = is_jalr ? ((rs1_data + imm_data) & 32'hFFFF_FFFE) : (ex_pc + imm_data);
        m_redirect = 0;
        m_merr     = 0;
        if (trap_valid) begin
            m_pc = trap_vector; m_mode = 1; m_redirect = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (wants && (tgt % 4) == 0) begin
                m_pc = tgt; m_redirect = 1;
            end else if (wants) begin
                m_mode = 2; m_merr = 1; m_maddr = tgt;
            end else if (fetch_ready) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       pc,                   m_pc);
        chk({tag, ".fvalid"},   {31'd0, fetch_valid}, {31'd0, m_mode == 1});
        chk({tag, ".redirect"}, {31'd0, redirect},    {31'd0, m_redirect});
        chk({tag, ".merr"},     {31'd0, misalign_err}, {31'd0, m_merr});
        chk({tag, ".maddr"},    misalign_addr,        m_maddr);
`ifdef PC_GEN_PERF_CNT_EN
        chk({tag, ".cnt"},      32'(redirect_count),  32'(m_cnt));
`endif
    endtask

    // One clock: model follows the edge, DUT is sampled 1ns later, returns at negedge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic clear_ex();
        ex_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0; branch_taken = 0;
        ex_pc = 0; imm_data = 0; rs1_data = 0; trap_valid = 0; trap_vector = 0;
    endtask

    initial begin
        rst_n = 0; fetch_ready = 1;
        clear_ex();
        model_reset();
        tick("rst0");
        tick("rst1");
        chk("reset_pc", pc, 32'h1000);
        chk("reset_fv", {31'd0, fetch_valid}, 32'd0);

        // Boot then sequential fetch.
        rst_n = 1;
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        tick("boot");
        chk("seq0", pc, 32'h1000);
        tick("seq1");
        chk("seq1", pc, 32'h1004);
        tick("seq2");
        chk("seq2", pc, 32'h1008);

        // Stall for three cycles.
        fetch_ready = 0;
        repeat (3) tick("stall");
        chk("stall_pc", pc, 32'h1008);
        fetch_ready = 1;
        tick("resume");
        chk("resume_pc", pc, 32'h100C);

        // Taken branch during a stall, then a not-taken branch.
        fetch_ready = 0;
        ex_valid = 1; is_branch = 1; branch_taken = 1; ex_pc = 32'h1000; imm_data = 32'h20;
        tick("br_taken");
        chk("br_pc", pc, 32'h1020);
        chk("br_redirect", {31'd0, redirect}, 32'd1);
        branch_taken = 0; imm_data = 32'h100;
        tick("br_not");
        chk("br_not_redirect", {31'd0, redirect}, 32'd0);
        fetch_ready = 1;

        // JALR wins over JAL/branch; then a misaligned JALR halts.
        clear_ex();
        ex_valid = 1; is_jalr = 1; is_jal = 1; is_branch = 1; branch_taken = 1;
        rs1_data = 32'h3004; imm_data = 32'h1; ex_pc = 32'h5000;
        tick("jalr");
        chk("jalr_pc", pc, 32'h3004);
        clear_ex();
        ex_valid = 1; is_jalr = 1; rs1_data = 32'h2000; imm_data = 32'h6;
        tick("mis");
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_addr", misalign_addr, 32'h2006);
        clear_ex();
        ex_valid = 1; is_jal = 1; ex_pc = 32'h4000; imm_data = 32'h40;
        tick("halt_ign");
        chk("halt_pc", pc, 32'h3004);

        // Trap out of HALT, then trap beats a simultaneous JAL.
        clear_ex();
        trap_valid = 1; trap_vector = 32'h80;
        tick("trap");
        chk("trap_pc", pc, 32'h80);
        ex_valid = 1; is_jal = 1; ex_pc = 32'h4000; imm_data = 32'h8; trap_vector = 32'h200;
        tick("trap_jal");
        chk("trap_jal_pc", pc, 32'h200);

        // Wrap-around of sequential fetch.
        clear_ex();
        trap_valid = 1; trap_vector = 32'hFFFF_FFFC;
        tick("wrap_set");
        trap_valid = 0;
        tick("wrap");
        chk("wrap_pc", pc, 32'h0);

`ifdef PC_GEN_PERF_CNT_EN
        // Five back-to-back redirects saturate a 2-bit counter.
        trap_valid = 1;
        for (int k = 0; k < 5; k++) begin
            trap_vector = 32'h100 + 32'(k) * 4;
            tick("sat");
        end
        trap_valid = 0;
        tick("sat_end");
        chk("cnt_sat", 32'(redirect_count), 32'd3);
`endif

        // Asynchronous reset mid-operation.
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        tick("async_rst_hold");
        rst_n = 1;
        tick("async_boot");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            fetch_ready  = $urandom_range(0, 3) != 0;
            ex_valid     = $urandom_range(0, 1);
            is_branch    = $urandom_range(0, 1);
            is_jal       = $urandom_range(0, 3) == 0;
            is_jalr      = $urandom_range(0, 3) == 0;
            branch_taken = $urandom_range(0, 1);
            ex_pc        = $urandom & 32'hFFFF_FFFC;
            imm_data     = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                                       : ($urandom & 32'hFFFF_FFFC);
            rs1_data     = $urandom;
            trap_valid   = $urandom_range(0, 15) == 0;
            trap_vector  = $urandom & 32'hFFFF_FFFC;
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_gen
`default_nettype wire
